// File: rtl/dps_request_arbiter.sv
// Round-robin arbiter sharing the DPS request port between M0 (CPU LSU) and M1 (debug/DMA).
// Define DPS_ARB_TIMEOUT_EN to build the read watchdog (P_TIMEOUT_CYCLES).
module dps_request_arbiter #(
    parameter int unsigned P_TIMEOUT_CYCLES = 255
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iM0_REQ,
    output logic        oM0_BUSY,
    input  logic        iM0_RW,
    input  logic [31:0] iM0_ADDR,
    input  logic [31:0] iM0_DATA,
    output logic        oM0_VALID,
    output logic [31:0] oM0_DATA,
    input  logic        iM1_REQ,
    output logic        oM1_BUSY,
    input  logic        iM1_RW,
    input  logic [31:0] iM1_ADDR,
    input  logic [31:0] iM1_DATA,
    output logic        oM1_VALID,
    output logic [31:0] oM1_DATA,
    output logic        oDPS_REQ,
    input  logic        iDPS_BUSY,
    output logic        oDPS_RW,
    output logic [31:0] oDPS_ADDR,
    output logic [31:0] oDPS_DATA,
    input  logic        iDPS_VALID,
    input  logic [31:0] iDPS_DATA,
    output logic        oTIMEOUT
);
    // Handshake: a master holds REQ and its fields stable until it sees BUSY low;
    // the DPS takes a request in any cycle where oDPS_REQ is high and iDPS_BUSY is low.
    typedef enum logic {
        STATE_IDLE    = 1'b0,
        STATE_RD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] L_TERM = 8'(P_TIMEOUT_CYCLES - 1);

    state_t      b_state;
    state_t      next_state;
    logic        b_owner;
    logic        b_last;
    logic        grant_valid;
    logic        grant_sel;
    logic        accept;
    logic        rd_accept;
    logic        rd_done;
    logic        timeout_hit;
    logic [31:0] resp_data;

    // Tie goes to the master that was not granted last.
    always_comb begin
        grant_valid = (b_state == STATE_IDLE) && (iM0_REQ || iM1_REQ);
        if (iM0_REQ && iM1_REQ) begin
            grant_sel = ~b_last;
        end else begin
            grant_sel = iM1_REQ;
        end
        accept    = grant_valid && !iDPS_BUSY;
        rd_accept = accept && !oDPS_RW;
    end

    assign oDPS_REQ  = grant_valid;
    assign oDPS_RW   = grant_valid && (grant_sel ? iM1_RW : iM0_RW);
    assign oDPS_ADDR = !grant_valid ? 32'h0 : (grant_sel ? iM1_ADDR : iM0_ADDR);
    assign oDPS_DATA = !grant_valid ? 32'h0 : (grant_sel ? iM1_DATA : iM0_DATA);
    assign oM0_BUSY  = !(accept && !grant_sel);
    assign oM1_BUSY  = !(accept && grant_sel);

`ifdef DPS_ARB_TIMEOUT_EN
    logic [7:0] b_count;
    logic       b_orphan;

    // A real response in the terminal cycle wins over the watchdog.
    assign timeout_hit = (b_state == STATE_RD_WAIT) && !iDPS_VALID && (b_count == L_TERM);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            b_count  <= 8'h0;
            b_orphan <= 1'b0;
        end else begin
            if (rd_accept) begin
                b_count <= 8'h0;
            end else if ((b_state == STATE_RD_WAIT) && !iDPS_VALID) begin
                b_count <= b_count + 8'h1;
            end
            if (timeout_hit) begin
                b_orphan <= 1'b1;
            end else if (b_orphan && (b_state == STATE_IDLE) && iDPS_VALID) begin
                b_orphan <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^L_TERM;
    assign timeout_hit        = 1'b0;
`endif

    assign rd_done   = (b_state == STATE_RD_WAIT) && (iDPS_VALID || timeout_hit);
    assign resp_data = iDPS_VALID ? iDPS_DATA : 32'hFFFF_FFFF;
    assign oTIMEOUT  = timeout_hit;

    always_comb begin
        oM0_VALID = 1'b0;
        oM1_VALID = 1'b0;
        oM0_DATA  = 32'h0;
        oM1_DATA  = 32'h0;
        if (rd_done) begin
            if (b_owner) begin
                oM1_VALID = 1'b1;
                oM1_DATA  = resp_data;
            end else begin
                oM0_VALID = 1'b1;
                oM0_DATA  = resp_data;
            end
        end
    end

    always_comb begin
        next_state = b_state;
        case (b_state)
            STATE_IDLE:    if (rd_accept) next_state = STATE_RD_WAIT;
            STATE_RD_WAIT: if (rd_done) next_state = STATE_IDLE;
            default:       next_state = STATE_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            b_state <= STATE_IDLE;
            b_owner <= 1'b0;
            b_last  <= 1'b1;
        end else begin
            b_state <= next_state;
            if (accept) begin
                b_last <= grant_sel;
            end
            if (rd_accept) begin
                b_owner <= grant_sel;
            end
        end
    end
endmodule

// File: tb/tb_dps_request_arbiter.sv
// Bench for dps_request_arbiter: directed vector table, corner sequences, random run against a model.
module tb_dps_request_arbiter;
    localparam int unsigned P_TMO = 4;
    localparam int OW = 135;
    localparam logic [31:0] DK = 32'h5A5A_0000;
`ifdef DPS_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req, m0_busy, m0_rw, m0_valid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_busy, m1_rw, m1_valid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        dps_req, dps_busy, dps_rw, dps_valid, timeout;
    logic [31:0] dps_addr, dps_wdata, dps_rdata;

    dps_request_arbiter #(.P_TIMEOUT_CYCLES(P_TMO)) dut (
        .iCLOCK(clk), .inRESET(rst_n),
        .iM0_REQ(m0_req), .oM0_BUSY(m0_busy), .iM0_RW(m0_rw), .iM0_ADDR(m0_addr),
        .iM0_DATA(m0_wdata), .oM0_VALID(m0_valid), .oM0_DATA(m0_rdata),
        .iM1_REQ(m1_req), .oM1_BUSY(m1_busy), .iM1_RW(m1_rw), .iM1_ADDR(m1_addr),
        .iM1_DATA(m1_wdata), .oM1_VALID(m1_valid), .oM1_DATA(m1_rdata),
        .oDPS_REQ(dps_req), .iDPS_BUSY(dps_busy), .oDPS_RW(dps_rw), .oDPS_ADDR(dps_addr),
        .oDPS_DATA(dps_wdata), .iDPS_VALID(dps_valid), .iDPS_DATA(dps_rdata),
        .oTIMEOUT(timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [OW-1:0] exp_q[$];

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1;
        logic        dbusy, dvalid;
        logic [31:0] rdata;
        logic        eb0, eb1, ereq, erw;
        logic [31:0] eaddr;
        logic        ev0, ev1;
    } vec_t;
    vec_t tbl[17];

    // reference model state (abstract: waiting flag, owner/last as master index)
    bit   m_wait;
    int   m_owner, m_last, m_cnt;
    logic rq[2];
    logic rwv[2];
    logic [31:0] ad[2];

    function automatic logic [OW-1:0] dut_vec();
        return {m0_busy, m1_busy, m0_valid, m1_valid, m0_rdata, m1_rdata,
                dps_req, dps_rw, dps_addr, dps_wdata, timeout};
    endfunction

    function automatic logic [OW-1:0] pack(logic b0, logic b1, logic v0, logic v1,
                                           logic [31:0] vd0, logic [31:0] vd1, logic dreq,
                                           logic drw, logic [31:0] daddr, logic [31:0] ddata,
                                           logic tmo);
        return {b0, b1, v0, v1, vd0, vd1, dreq, drw, daddr, ddata, tmo};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // driver
    task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic dbusy,
                         input logic dvalid, input logic [31:0] rdata);
        m0_req = r0; m0_rw = w0; m0_addr = a0; m0_wdata = a0 ^ DK;
        m1_req = r1; m1_rw = w1; m1_addr = a1; m1_wdata = a1 ^ DK;
        dps_busy = dbusy; dps_valid = dvalid; dps_rdata = rdata;
    endtask

    task automatic check(input string name, input logic [OW-1:0] exp);
        logic [OW-1:0] act;
        act = dut_vec();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("reset_state", pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle();
        rst_n = 1'b1;
        m_wait = 0; m_owner = 0; m_last = 1; m_cnt = 0;
        rq[0] = 0; rq[1] = 0;
    endtask

    task automatic read_then_idle(input logic [31:0] addr, input int waits);
        drive(1, 0, 0, 0, addr, 0, 0, 0, 0);
        #1;
        check("rd_accept", pack(0, 1, 0, 0, 0, 0, 1, 0, addr, addr ^ DK, 0));
        cycle();
        for (int k = 0; k < waits; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            check("rd_wait", pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            cycle();
        end
    endtask

    // model: expected outputs for the current inputs, then advance one clock
    task automatic model_cycle(input logic dbusy, input logic dvalid, input logic [31:0] rdata);
        logic [1:0]  eb, ev;
        logic [31:0] evd[2];
        logic        dreq, drw, tmo;
        logic [31:0] da, dd;
        int          g;
        bit          acc, done;
        eb = 2'b11; ev = 2'b00; evd[0] = 0; evd[1] = 0;
        dreq = 0; drw = 0; tmo = 0; da = 0; dd = 0; g = -1; acc = 0; done = 0;
        if (!m_wait) begin
            if (rq[0] && rq[1]) g = 1 - m_last;
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
            if (g >= 0) begin
                dreq = 1; drw = rwv[g]; da = ad[g]; dd = ad[g] ^ DK;
                acc = !dbusy;
                if (acc) eb[g] = 1'b0;
            end
        end else if (dvalid) begin
            ev[m_owner] = 1'b1; evd[m_owner] = rdata; done = 1;
        end else if (TMO_EN && m_cnt == int'(P_TMO) - 1) begin
            ev[m_owner] = 1'b1; evd[m_owner] = 32'hFFFF_FFFF; tmo = 1; done = 1;
        end
        exp_q.push_back(pack(eb[0], eb[1], ev[0], ev[1], evd[0], evd[1], dreq, drw, da, dd, tmo));
        if (m_wait) begin
            if (done) m_wait = 0;
            else m_cnt++;
        end else if (acc) begin
            m_last = g;
            rq[g] = 0;
            if (!rwv[g]) begin
                m_wait = 1; m_owner = g; m_cnt = 0;
            end
        end
    endtask

    initial begin
        tbl = '{
            '{0,0,0,0, 32'h0,   32'h0,   0,0,32'h0,      1,1,0,0,32'h0,   0,0},
            '{1,1,1,1, 32'h10,  32'h20,  0,0,32'h0,      0,1,1,1,32'h10,  0,0},
            '{1,1,1,1, 32'h10,  32'h20,  0,0,32'h0,      1,0,1,1,32'h20,  0,0},
            '{1,1,1,1, 32'h10,  32'h20,  0,0,32'h0,      0,1,1,1,32'h10,  0,0},
            '{1,1,1,1, 32'h10,  32'h20,  0,0,32'h0,      1,0,1,1,32'h20,  0,0},
            '{1,0,0,0, 32'h120, 32'h0,   0,0,32'h0,      0,1,1,0,32'h120, 0,0},
            '{0,0,0,0, 32'h0,   32'h0,   0,0,32'h0,      1,1,0,0,32'h0,   0,0},
            '{0,0,0,0, 32'h0,   32'h0,   0,1,32'h5,      1,1,0,0,32'h0,   1,0},
            '{0,0,0,0, 32'h0,   32'h0,   0,0,32'h0,      1,1,0,0,32'h0,   0,0},
            '{1,1,1,0, 32'h40,  32'h300, 1,0,32'h0,      1,1,1,0,32'h300, 0,0},
            '{1,1,1,0, 32'h40,  32'h300, 1,0,32'h0,      1,1,1,0,32'h300, 0,0},
            '{1,1,1,0, 32'h40,  32'h300, 1,0,32'h0,      1,1,1,0,32'h300, 0,0},
            '{1,1,1,0, 32'h40,  32'h300, 0,0,32'h0,      1,0,1,0,32'h300, 0,0},
            '{1,0,1,0, 32'h40,  32'h0,   0,0,32'h0,      1,1,0,0,32'h0,   0,0},
            '{1,0,1,0, 32'h40,  32'h0,   0,1,32'hCAFE,   1,1,0,0,32'h0,   0,1},
            '{1,0,1,0, 32'h40,  32'h0,   0,0,32'h0,      0,1,1,1,32'h40,  0,0},
            '{0,0,0,0, 32'h0,   32'h0,   0,0,32'h0,      1,1,0,0,32'h0,   0,0}
        };
        #2;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1,
                  tbl[i].dbusy, tbl[i].dvalid, tbl[i].rdata);
            #1;
            check($sformatf("vec%0d", i),
                  pack(tbl[i].eb0, tbl[i].eb1, tbl[i].ev0, tbl[i].ev1,
                       tbl[i].ev0 ? tbl[i].rdata : 32'h0, tbl[i].ev1 ? tbl[i].rdata : 32'h0,
                       tbl[i].ereq, tbl[i].erw, tbl[i].eaddr,
                       tbl[i].ereq ? (tbl[i].eaddr ^ DK) : 32'h0, 1'b0));
            cycle();
        end

        // reset while a read is outstanding and its response is on the bus
        do_reset();
        read_then_idle(32'h500, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        #1;
        check("rd_resp_pre_reset", pack(1, 1, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_read", pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle();
        rst_n = 1'b1;
        drive(1, 1, 1, 1, 32'h60, 32'h70, 0, 0, 0);
        #1;
        check("tie_after_reset", pack(0, 1, 0, 0, 0, 0, 1, 1, 32'h60, 32'h60 ^ DK, 0));
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
        #1;
        check("stale_valid_idle", pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle();

`ifdef DPS_ARB_TIMEOUT_EN
        do_reset();
        read_then_idle(32'h900, P_TMO - 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("tmo_fire", pack(1, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1));
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        #1;
        check("tmo_late_drop", pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle();
        do_reset();
        read_then_idle(32'h904, P_TMO - 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5);
        #1;
        check("tmo_vs_resp", pack(1, 1, 1, 0, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0));
        cycle();
`endif

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2; i++) begin
            rwv[i] = 0; ad[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            logic        dbusy, dvalid;
            logic [31:0] rdata;
            for (int m = 0; m < 2; m++) begin
                if (!rq[m] && $urandom_range(0, 2) == 0) begin
                    rq[m] = 1; rwv[m] = 1'($urandom_range(0, 1)); ad[m] = $urandom & 32'hFFFF_FFFC;
                end
            end
            dbusy  = ($urandom_range(0, 3) == 0);
            dvalid = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rdata  = $urandom;
            drive(rq[0], rq[1], rwv[0], rwv[1], ad[0], ad[1], dbusy, dvalid, rdata);
            model_cycle(dbusy, dvalid, rdata);
            #1;
            check($sformatf("rand%0d", n), exp_q.pop_front());
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dps_request_arbiter.md
# dps_request_arbiter

Two-master arbiter for the default peripheral system request port. It sits between the DPS register interface (REQ/BUSY/RW/ADDR/DATA, VALID/DATA response) and two requesters: M0 is the CPU load/store unit and M1 is the debug/DMA master. It grants the single DPS port round-robin, holds ownership across an outstanding read, and routes the read response back to the owner. An optional watchdog terminates reads that never return.

## Interface
- P_TIMEOUT_CYCLES, 255: RD_WAIT cycles before a read is force-terminated. Range 1..255; only used with the timeout macro.
- iCLOCK  in  1  system clock; the same clock as the DPS interface.
- inRESET  in  1  asynchronous active-low reset.
- iM0_REQ / iM1_REQ  in  1  request; held stable until accepted.
- oM0_BUSY / oM1_BUSY  out  1  request is not accepted this cycle.
- iM0_RW / iM1_RW  in  1  1 = write.
- iM0_ADDR / iM1_ADDR  in  32  DPS byte address.
- iM0_DATA / iM1_DATA  in  32  write data.
- oM0_VALID / oM1_VALID  out  1  read response pulse.
- oM0_DATA / oM1_DATA  out  32  read data; 0 when VALID is low.
- oDPS_REQ  out  1  request to the DPS.
- iDPS_BUSY  in  1  DPS busy; the DPS does not accept the request.
- oDPS_RW  out  1  DPS read/write select; 1 = write.
- oDPS_ADDR  out  32  DPS byte address.
- oDPS_DATA  out  32  DPS write data.
- iDPS_VALID  in  1  DPS read response valid.
- iDPS_DATA  in  32  DPS read data.
- oTIMEOUT  out  1  one-cycle pulse when a read is force-terminated.

## Operation
- States: IDLE, RD_WAIT. Registers:
  - b_state
  - b_owner: the master owning the outstanding read.
  - b_last: the last granted master. Reset value 1, so M0 wins the first tie.
  - b_orphan: the DPS still owes a response that will be dropped.
  - b_count: 8-bit watchdog counter.
- Grant (combinational, IDLE only):
  - Exactly one master requesting: that master is granted.
  - Both requesting: the master != b_last is granted.
  - No request: no grant.
  - oDPS_REQ = a grant exists. oDPS_RW, oDPS_ADDR and oDPS_DATA are muxed from the granted master, and are 0 when there is no grant.
- Accept = oDPS_REQ && !iDPS_BUSY.
  - oMx_BUSY = !(state == IDLE && granted to x && !iDPS_BUSY).
  - On accept, b_last <= the granted master.
- Write accept: the transfer completes; the state stays IDLE.
- Read accept: state -> RD_WAIT, b_owner <= the granted master, b_count <= 0.
- RD_WAIT:
  - iDPS_VALID high: oM[b_owner]_VALID = 1 and oM[b_owner]_DATA = iDPS_DATA, both in the same cycle. State -> IDLE.
  - iDPS_VALID low: b_count increments.
  - No grant is issued in RD_WAIT; both BUSY outputs are 1.
- iDPS_VALID while in IDLE:
  - b_orphan set: the response is dropped and b_orphan clears.
  - b_orphan clear: the response is ignored.
  - No master VALID is raised in either case.
- Reset (asynchronous, mid-operation included) returns the block to:
  - IDLE
  - b_owner = 0
  - b_last = 1
  - b_orphan = 0
  - b_count = 0
  - all outputs 0, except oM0_BUSY = oM1_BUSY = 1 whenever the master is not granted (per the BUSY equation).
- A pending read is lost on reset. No response is delivered to either master.

## Timing
- Request-to-DPS latency is 0 cycles: oDPS_REQ follows iMx_REQ combinationally in IDLE.
- Read: accept at cycle N; earliest response at N+1. oMx_VALID appears in the same cycle as iDPS_VALID, and the next accept is possible in the cycle after it.
- Writes: back-to-back writes are possible every cycle when iDPS_BUSY is low. With both masters requesting, grants alternate 0,1,0,1.
- iDPS_VALID arriving in the same cycle as the timeout is a response, not a timeout: VALID carries iDPS_DATA and oTIMEOUT stays 0.

## Configuration
- DPS_ARB_TIMEOUT_EN defined:
  - In RD_WAIT, when b_count == P_TIMEOUT_CYCLES-1 with iDPS_VALID low, the block pulses:
    - oM[b_owner]_VALID with data 32'hFFFF_FFFF
    - oTIMEOUT
  - It then sets b_orphan and goes to IDLE.
  - New requests remain gated by iDPS_BUSY.
- Not defined:
  - No counter and no b_orphan logic are built.
  - RD_WAIT waits indefinitely.
  - oTIMEOUT is tied to 0.

## Test plan
- M0 reads 0x120; DPS returns 0x0000_0005 two cycles later -> oM0_VALID for 1 cycle with data 5; oM1_VALID stays 0; state returns to IDLE.
- M0 and M1 request writes simultaneously, held for 4 cycles, iDPS_BUSY low -> DPS sees M0,M1,M0,M1; each master's BUSY is low only on its grant cycles.
- M1 reads while iDPS_BUSY is high for 3 cycles -> oDPS_REQ stays high with M1's address and oM1_BUSY stays high; accept on cycle 4; oM0 requests are blocked until the response.
- Timeout (macro on, P_TIMEOUT_CYCLES = 4): M0 reads, no response -> 4 cycles after accept, oM0_VALID with 0xFFFF_FFFF and oTIMEOUT pulse. A late iDPS_VALID carrying 0x1234 is then dropped and no master sees it.
- Timeout coincident with a response (macro on): iDPS_VALID with 0xA5A5_A5A5 arrives in the terminal-count cycle -> oM0_VALID with 0xA5A5_A5A5 and oTIMEOUT = 0.
- inRESET asserted in RD_WAIT -> all outputs drop immediately. After release, M0 wins a tie, and a stale iDPS_VALID is ignored.
